jaa_bytecode_fetch: RTL
=======================

Name: jaa_bytecode_fetch

Overview:
Upstream stage of the Java-bytecode-to-ARM translator. It reads bytecode bytes from a synchronous byte memory and assembles each opcode with its operand bytes into one packet. Packets go to the translator over a valid/ready handshake, so the translator never parses raw byte streams or tracks operand counts itself.

Parameters:
ADDR_WIDTH, 10, byte-address width of the bytecode memory (1024 bytes).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begin fetching at address 0 (honoured only in IDLE or DONE)
code_len  in  ADDR_WIDTH+1  number of valid bytecode bytes; sampled on start
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_WIDTH  memory byte address
mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  packet valid
out_ready  in  1  translator accepts packet
out_opcode  out  8  Java opcode
out_operand  out  16  operand bytes, big-endian; 1 byte in [7:0] with [15:8]=0; 0 if none
out_num_operands  out  2  0, 1 or 2
out_pc  out  ADDR_WIDTH  address of the opcode byte
out_unsupported  out  1  opcode not in length table
done  out  1  all bytes consumed; held until start or reset
truncated  out  1  last opcode's operands ran past code_len; sticky until start or reset

Behaviour:
- Reset (synchronous, active-high) sets state IDLE, pc=0, and all outputs to 0. Reset mid-packet drops out_valid at the next edge. Any partial operand is discarded.
- States: IDLE, RD_OP, WAIT_OP, RD_OPND, WAIT_OPND, PRESENT, DONE.
- IDLE/DONE + start: latch code_len and clear done and truncated. Go to DONE if code_len==0, otherwise go to RD_OP with pc=0. start in any other state is ignored.
- RD_OP: mem_rd_en=1, mem_addr=pc. Next state is WAIT_OP.
- WAIT_OP: latch opcode=mem_rdata and op_pc=pc. Set pc=pc+1, operand=0, and rem=length(opcode).
  - rem==0: go to PRESENT.
  - pc+1 >= code_len: set truncated=1 and go to DONE. No packet is emitted.
  - Otherwise: go to RD_OPND.
- RD_OPND: mem_rd_en=1, mem_addr=pc. Next state is WAIT_OPND.
- WAIT_OPND: set operand={operand[7:0], mem_rdata}, pc=pc+1, rem=rem-1.
  - rem becomes 0: go to PRESENT.
  - pc+1 >= code_len: set truncated=1 and go to DONE.
  - Otherwise: go to RD_OPND.
- mem_rd_en is 0 in every state except RD_OP and RD_OPND.
- PRESENT: out_valid=1. All out_* fields stay stable until out_valid && out_ready.
  - On handshake: out_valid falls next cycle. Go to DONE if pc==code_len, otherwise go to RD_OP.
  - A valid, once raised, is never withdrawn except by reset.
- Latency:
  - 0-operand opcode: out_valid 2 cycles after entering RD_OP.
  - 1-operand opcode: 4 cycles.
  - 2-operand opcode: 6 cycles.
  - Back-to-back 0-operand packets with out_ready tied high: one packet per 3 cycles.
- Length table:
  - 0 operands: 0x03-0x08 iconst_0..5, 0x1A-0x1D iload_0..3, 0x3B-0x3E istore_0..3, 0x60 iadd, 0x59-0x5F dup/dup_x1/dup_x2/dup2/dup2_x1/dup2_x2/swap.
  - 1 operand: 0x10 bipush, 0x15 iload, 0x36 istore.
  - 2 operands: 0x11 sipush.
  - Any other opcode: length 0 with out_unsupported=1. It is still emitted as a packet.
- pc arithmetic is ADDR_WIDTH+1 bits. With code_len=1024 it reaches 1024 without wrapping, and mem_addr uses pc[ADDR_WIDTH-1:0].

Decomposition:
- Package jaa_pkg:
  - opcode localparams: ICONST_0, ILOAD, ISTORE, BIPUSH, SIPUSH, IADD, DUP..SWAP.
  - state encoding for this FSM.
  - the packet field widths.
  - The translator will reuse the same opcode constants.
- Sub-module jaa_opcode_length: combinational, opcode[7:0] -> num_operands[1:0] and unsupported. It is shared with the translator for its operand count.

Test Plan:
- Bytes 03 3C 1B 60, code_len=4, out_ready=1 -> four packets (03,pc0), (3C,pc1), (1B,pc2), (60,pc3), each with num_operands=0 and operand=0000. done=1 after the 4th handshake; truncated=0.
- Bytes 10 7F 11 12 34 36 05, code_len=7 -> three packets:
  - (10, operand 007F, n=1, pc0)
  - (11, operand 1234, n=2, pc2)
  - (36, operand 0005, n=1, pc5)
  - The 2-operand packet is valid 6 cycles after its RD_OP.
- Backpressure: out_ready held 0 for 5 cycles on packet 15 2A -> out_valid stays 1 with fields stable and mem_rd_en=0. Handshake occurs on the first cycle out_ready=1, and out_valid=0 the next cycle.
- Truncation: bytes 11 12, code_len=2 -> no packet, truncated=1, done=1. A subsequent start with code_len=1, byte 03 -> truncated cleared and one packet (03) emitted.
- Unsupported and edge cases:
  - Byte FF, code_len=1 -> packet (FF, n=0, out_unsupported=1), then done.
  - start with code_len=0 -> done=1 next cycle, no mem_rd_en.
- Reset asserted during WAIT_OPND of 11 12 34 -> next cycle state IDLE, out_valid=0, done=0. A fresh start refetches from pc 0.

Source files
------------

// File: rtl/jaa_pkg.sv
// Shared definitions for the bytecode fetch stage and the downstream translator:
// opcode constants, fetch FSM state encoding and packet field widths.
package jaa_pkg;

    localparam int OPCODE_W   = 8;
    localparam int OPERAND_W  = 16;
    localparam int NUM_OPND_W = 2;

    localparam logic [7:0] ICONST_0 = 8'h03;
    localparam logic [7:0] ICONST_5 = 8'h08;
    localparam logic [7:0] BIPUSH   = 8'h10;
    localparam logic [7:0] SIPUSH   = 8'h11;
    localparam logic [7:0] ILOAD    = 8'h15;
    localparam logic [7:0] ILOAD_0  = 8'h1A;
    localparam logic [7:0] ILOAD_3  = 8'h1D;
    localparam logic [7:0] ISTORE   = 8'h36;
    localparam logic [7:0] ISTORE_0 = 8'h3B;
    localparam logic [7:0] ISTORE_3 = 8'h3E;
    localparam logic [7:0] DUP      = 8'h59;
    localparam logic [7:0] DUP_X1   = 8'h5A;
    localparam logic [7:0] DUP_X2   = 8'h5B;
    localparam logic [7:0] DUP2     = 8'h5C;
    localparam logic [7:0] DUP2_X1  = 8'h5D;
    localparam logic [7:0] DUP2_X2  = 8'h5E;
    localparam logic [7:0] SWAP     = 8'h5F;
    localparam logic [7:0] IADD     = 8'h60;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_OP,
        ST_WAIT_OP,
        ST_RD_OPND,
        ST_WAIT_OPND,
        ST_PRESENT,
        ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/jaa_bytecode_fetch_opcode_length.sv
// Operand-count lookup for the supported Java opcode subset; unknown opcodes
// report zero operands and raise unsupported.
module jaa_opcode_length
    import jaa_pkg::*;
(
    input  logic [OPCODE_W-1:0]   opcode,
    output logic [NUM_OPND_W-1:0] num_operands,
    output logic                  unsupported
);

    always_comb begin
        num_operands = 2'd0;
        unsupported  = 1'b0;
        if (opcode inside {[ICONST_0:ICONST_5], [ILOAD_0:ILOAD_3],
                           [ISTORE_0:ISTORE_3], [DUP:SWAP], IADD}) begin
            num_operands = 2'd0;
        end else if (opcode inside {BIPUSH, ILOAD, ISTORE}) begin
            num_operands = 2'd1;
        end else if (opcode == SIPUSH) begin
            num_operands = 2'd2;
        end else begin
            unsupported = 1'b1;
        end
    end

endmodule

// File: rtl/jaa_bytecode_fetch.sv
// Fetches bytecode bytes from a 1-cycle synchronous memory and emits one
// opcode+operand packet per instruction over a valid/ready handshake.
module jaa_bytecode_fetch
    import jaa_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   code_len,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPCODE_W-1:0]   out_opcode,
    output logic [OPERAND_W-1:0]  out_operand,
    output logic [NUM_OPND_W-1:0] out_num_operands,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_unsupported,
    output logic                  done,
    output logic                  truncated
);

    localparam int PC_W = ADDR_WIDTH + 1;

    fetch_state_t          state, state_next;
    logic [PC_W-1:0]       pc, len, pc_inc;
    logic                  last_byte;
    logic [NUM_OPND_W-1:0] rem;
    logic [NUM_OPND_W-1:0] lut_num;
    logic                  lut_unsup;

    // Looked up directly on the returning byte so WAIT_OP can branch on it.
    jaa_opcode_length u_opcode_length (
        .opcode       (mem_rdata),
        .num_operands (lut_num),
        .unsupported  (lut_unsup)
    );

    assign pc_inc    = pc + PC_W'(1);
    assign last_byte = (pc_inc >= len);
    assign mem_addr  = pc[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = (code_len == '0) ? ST_DONE : ST_RD_OP;
            end
            ST_RD_OP: begin
                mem_rd_en  = 1'b1;
                state_next = ST_WAIT_OP;
            end
            ST_WAIT_OP: begin
                if (lut_num == 2'd0) state_next = ST_PRESENT;
                else if (last_byte)  state_next = ST_DONE;
                else                 state_next = ST_RD_OPND;
            end
            ST_RD_OPND: begin
                mem_rd_en  = 1'b1;
                state_next = ST_WAIT_OPND;
            end
            ST_WAIT_OPND: begin
                if (rem == 2'd1)    state_next = ST_PRESENT;
                else if (last_byte) state_next = ST_DONE;
                else                state_next = ST_RD_OPND;
            end
            ST_PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = (pc == len) ? ST_DONE : ST_RD_OP;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc               <= '0;
            len              <= '0;
            rem              <= '0;
            out_opcode       <= '0;
            out_operand      <= '0;
            out_num_operands <= '0;
            out_pc           <= '0;
            out_unsupported  <= 1'b0;
            done             <= 1'b0;
            truncated        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        len       <= code_len;
                        pc        <= '0;
                        done      <= (code_len == '0);
                        truncated <= 1'b0;
                    end
                end
                ST_WAIT_OP: begin
                    out_opcode       <= mem_rdata;
                    out_pc           <= pc[ADDR_WIDTH-1:0];
                    out_operand      <= '0;
                    out_num_operands <= lut_num;
                    out_unsupported  <= lut_unsup;
                    rem              <= lut_num;
                    pc               <= pc_inc;
                    if (lut_num != 2'd0 && last_byte) begin
                        truncated <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                ST_WAIT_OPND: begin
                    out_operand <= {out_operand[7:0], mem_rdata};
                    rem         <= rem - 2'd1;
                    pc          <= pc_inc;
                    if (rem != 2'd1 && last_byte) begin
                        truncated <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready && pc == len) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
